// File: rtl/inverse_5x5.sv
// Q16.16 5x5 matrix inverter: ROM-fed matrix register A plus a sequential
// Gauss-Jordan engine (no pivoting) that writes the inverse into Ad.
module inverse_5x5 (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  address,
    output logic [31:0] data_out,
    output logic [31:0] A11, A12, A13, A14, A15,
    output logic [31:0] A21, A22, A23, A24, A25,
    output logic [31:0] A31, A32, A33, A34, A35,
    output logic [31:0] A41, A42, A43, A44, A45,
    output logic [31:0] A51, A52, A53, A54, A55,
    output logic [31:0] A11d, A12d, A13d, A14d, A15d,
    output logic [31:0] A21d, A22d, A23d, A24d, A25d,
    output logic [31:0] A31d, A32d, A33d, A34d, A35d,
    output logic [31:0] A41d, A42d, A43d, A44d, A45d,
    output logic [31:0] A51d, A52d, A53d, A54d, A55d
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_DIV, S_NORM, S_ELIM, S_NEXT, S_DONE
    } state_e;

    localparam logic [31:0] ONE = 32'h0001_0000;

    function automatic logic [31:0] rom_word(input logic [4:0] addr);
        logic [31:0] word;
        int k;
        k    = int'(addr);
        word = '0;
        if (k < 25) begin
            if (k % 5 == k / 5)          word = 32'h0002_0000;
            else if (k % 5 == k / 5 + 1) word = ONE;
        end
        return word;
    endfunction

    // Q16.16 product: full 64-bit signed product, arithmetic shift right by 16.
    function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ae, be, p;
        ae = {{32{a[31]}}, a};
        be = {{32{b[31]}}, b};
        p  = ae * be;
        return p[47:16];
    endfunction

    state_e      state_q, state_d;
    logic [31:0] data_out_q;
    logic [31:0] a_q  [25];
    logic [31:0] ad_q [25];
    logic [31:0] w_q  [5][10];
    logic [24:0] mask_q, mask_d;
    logic [2:0]  piv_q, piv_d, row_q, row_d;
    logic [3:0]  col_q, col_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [32:0] rem_q, quo_q;
    logic [31:0] mag_q, fac_q;
    logic        neg_q;

    logic        start;
    logic [31:0] pivot, recip, fac, mul_a, mul_b, prod;
    logic [32:0] rem_sh;
    logic        fit;
    logic [2:0]  first_row, next_row;

    assign start  = (mask_q == '1) && (state_q == S_IDLE);
    assign pivot  = w_q[piv_q][piv_q];
    assign recip  = neg_q ? -quo_q[31:0] : quo_q[31:0];
    assign rem_sh = {rem_q[31:0], quo_q[32]};
    assign fit    = rem_sh >= {1'b0, mag_q};
    // Factor a[i][p] must be the pre-elimination value, so it is held after column 0.
    assign fac    = (col_q == 4'd0) ? w_q[row_q][piv_q] : fac_q;
    assign mul_a  = (state_q == S_NORM) ? recip : fac;
    assign mul_b  = w_q[piv_q][col_q];
    assign prod   = qmul(mul_a, mul_b);
    assign first_row = (piv_q == 3'd0) ? 3'd1 : 3'd0;

    // NOTE: combinational blocks assign every output a default first, so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        piv_d    = piv_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        next_row = row_q + 3'd1;
        if (next_row == piv_q) next_row = next_row + 3'd1;
        mask_d = start ? '0 : mask_q;
        if (address < 5'd25) mask_d[address] = 1'b1;

        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_CHECK;
                piv_d   = 3'd0;
            end
            S_CHECK: begin
                state_d = (pivot == '0) ? S_IDLE : S_DIV;
                cnt_d   = '0;
            end
            S_DIV: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd32) begin
                    state_d = S_NORM;
                    col_d   = '0;
                end
            end
            S_NORM: begin
                col_d = col_q + 4'd1;
                if (col_q == 4'd9) begin
                    state_d = S_ELIM;
                    col_d   = '0;
                    row_d   = first_row;
                end
            end
            S_ELIM: begin
                col_d = col_q + 4'd1;
                if (col_q == 4'd9) begin
                    col_d = '0;
                    if (next_row > 3'd4) state_d = S_NEXT;
                    else                 row_d   = next_row;
                end
            end
            S_NEXT: begin
                if (piv_q == 3'd4) state_d = S_DONE;
                else begin
                    piv_d   = piv_q + 3'd1;
                    state_d = S_CHECK;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            piv_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            piv_q   <= piv_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the register arrays are cleared explicitly so every output and the working copy read 0 after reset.
            data_out_q <= '0;
            mask_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            mag_q      <= '0;
            fac_q      <= '0;
            neg_q      <= 1'b0;
            for (int k = 0; k < 25; k++) begin
                a_q[k]  <= '0;
                ad_q[k] <= '0;
            end
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 10; c++)
                    w_q[r][c] <= '0;
        end else begin
            data_out_q <= rom_word(address);
            mask_q     <= mask_d;
            if (address < 5'd25) a_q[address] <= rom_word(address);

            case (state_q)
                S_IDLE: if (start) begin
                    for (int r = 0; r < 5; r++)
                        for (int c = 0; c < 10; c++)
                            w_q[r][c] <= (c < 5) ? a_q[r*5 + c] : ((c - 5 == r) ? ONE : '0);
                end
                S_CHECK: begin
                    // Divider computes |2^32| / |pivot| unsigned; sign restored on use.
                    neg_q <= pivot[31];
                    mag_q <= pivot[31] ? (~pivot + 32'd1) : pivot;
                    rem_q <= '0;
                    quo_q <= 33'h1_0000_0000;
                    if (pivot == '0)
                        for (int k = 0; k < 25; k++) ad_q[k] <= '0;
                end
                S_DIV: begin
                    rem_q <= fit ? (rem_sh - {1'b0, mag_q}) : rem_sh;
                    quo_q <= {quo_q[31:0], fit};
                end
                S_NORM: w_q[piv_q][col_q] <= prod;
                S_ELIM: begin
                    w_q[row_q][col_q] <= w_q[row_q][col_q] - prod;
                    if (col_q == 4'd0) fac_q <= w_q[row_q][piv_q];
                end
                S_DONE: begin
                    for (int r = 0; r < 5; r++)
                        for (int c = 0; c < 5; c++)
                            ad_q[r*5 + c] <= w_q[r][c + 5];
                end
                default: ;
            endcase
        end
    end

    assign data_out = data_out_q;
    assign {A11, A12, A13, A14, A15} = {a_q[0],  a_q[1],  a_q[2],  a_q[3],  a_q[4]};
    assign {A21, A22, A23, A24, A25} = {a_q[5],  a_q[6],  a_q[7],  a_q[8],  a_q[9]};
    assign {A31, A32, A33, A34, A35} = {a_q[10], a_q[11], a_q[12], a_q[13], a_q[14]};
    assign {A41, A42, A43, A44, A45} = {a_q[15], a_q[16], a_q[17], a_q[18], a_q[19]};
    assign {A51, A52, A53, A54, A55} = {a_q[20], a_q[21], a_q[22], a_q[23], a_q[24]};
    assign {A11d, A12d, A13d, A14d, A15d} = {ad_q[0],  ad_q[1],  ad_q[2],  ad_q[3],  ad_q[4]};
    assign {A21d, A22d, A23d, A24d, A25d} = {ad_q[5],  ad_q[6],  ad_q[7],  ad_q[8],  ad_q[9]};
    assign {A31d, A32d, A33d, A34d, A35d} = {ad_q[10], ad_q[11], ad_q[12], ad_q[13], ad_q[14]};
    assign {A41d, A42d, A43d, A44d, A45d} = {ad_q[15], ad_q[16], ad_q[17], ad_q[18], ad_q[19]};
    assign {A51d, A52d, A53d, A54d, A55d} = {ad_q[20], ad_q[21], ad_q[22], ad_q[23], ad_q[24]};

endmodule

// File: tb/tb_inverse_5x5.sv
// Directed bench for inverse_5x5: ROM sweep vectors, hand-computed inverse of
// the 2I + superdiagonal matrix, partial sweeps and asynchronous reset cases.
module tb_inverse_5x5;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] exp_data;
    } rom_vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  address;
    logic [31:0] data_out;
    logic [31:0] a_o  [25];
    logic [31:0] ad_o [25];

    rom_vec_t    rom_tab [32];
    logic [31:0] inv_tab [25];
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;

    inverse_5x5 dut (
        .clk(clk), .reset(reset), .address(address), .data_out(data_out),
        .A11(a_o[0]),  .A12(a_o[1]),  .A13(a_o[2]),  .A14(a_o[3]),  .A15(a_o[4]),
        .A21(a_o[5]),  .A22(a_o[6]),  .A23(a_o[7]),  .A24(a_o[8]),  .A25(a_o[9]),
        .A31(a_o[10]), .A32(a_o[11]), .A33(a_o[12]), .A34(a_o[13]), .A35(a_o[14]),
        .A41(a_o[15]), .A42(a_o[16]), .A43(a_o[17]), .A44(a_o[18]), .A45(a_o[19]),
        .A51(a_o[20]), .A52(a_o[21]), .A53(a_o[22]), .A54(a_o[23]), .A55(a_o[24]),
        .A11d(ad_o[0]),  .A12d(ad_o[1]),  .A13d(ad_o[2]),  .A14d(ad_o[3]),  .A15d(ad_o[4]),
        .A21d(ad_o[5]),  .A22d(ad_o[6]),  .A23d(ad_o[7]),  .A24d(ad_o[8]),  .A25d(ad_o[9]),
        .A31d(ad_o[10]), .A32d(ad_o[11]), .A33d(ad_o[12]), .A34d(ad_o[13]), .A35d(ad_o[14]),
        .A41d(ad_o[15]), .A42d(ad_o[16]), .A43d(ad_o[17]), .A44d(ad_o[18]), .A45d(ad_o[19]),
        .A51d(ad_o[20]), .A52d(ad_o[21]), .A53d(ad_o[22]), .A54d(ad_o[23]), .A55d(ad_o[24])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else             n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            address = 5'(i);
            step();
        end
    endtask

    task automatic check_a_rom(input string tag);
        for (int k = 0; k < 25; k++)
            check($sformatf("%s_A%0d%0d", tag, k / 5 + 1, k % 5 + 1), a_o[k], rom_tab[k].exp_data);
    endtask

    task automatic check_ad_inv(input string tag);
        for (int k = 0; k < 25; k++)
            check($sformatf("%s_A%0d%0dd", tag, k / 5 + 1, k % 5 + 1), ad_o[k], inv_tab[k]);
    endtask

    task automatic check_all_zero(input string tag, input bit with_a);
        for (int k = 0; k < 25; k++) begin
            check($sformatf("%s_A%0d%0dd", tag, k / 5 + 1, k % 5 + 1), ad_o[k], 32'h0);
            if (with_a) check($sformatf("%s_A%0d%0d", tag, k / 5 + 1, k % 5 + 1), a_o[k], 32'h0);
        end
    endtask

    // Called right after the edge that writes the last element; bounded wait.
    task automatic wait_ad_valid(input string tag);
        int cyc;
        cyc = 0;
        while (ad_o[0] == 32'h0 && cyc < 650) begin
            step();
            cyc++;
        end
        check({tag, "_latency_ok"}, 32'(cyc <= 602), 32'd1);
    endtask

    initial begin
        rom_tab = '{
            '{5'd0,  32'h0002_0000}, '{5'd1,  32'h0001_0000}, '{5'd2,  32'h0}, '{5'd3,  32'h0},
            '{5'd4,  32'h0},         '{5'd5,  32'h0}, '{5'd6,  32'h0002_0000}, '{5'd7,  32'h0001_0000},
            '{5'd8,  32'h0},         '{5'd9,  32'h0},         '{5'd10, 32'h0}, '{5'd11, 32'h0},
            '{5'd12, 32'h0002_0000}, '{5'd13, 32'h0001_0000}, '{5'd14, 32'h0}, '{5'd15, 32'h0},
            '{5'd16, 32'h0},         '{5'd17, 32'h0}, '{5'd18, 32'h0002_0000}, '{5'd19, 32'h0001_0000},
            '{5'd20, 32'h0},         '{5'd21, 32'h0},         '{5'd22, 32'h0}, '{5'd23, 32'h0},
            '{5'd24, 32'h0002_0000}, '{5'd25, 32'h0},         '{5'd26, 32'h0}, '{5'd27, 32'h0},
            '{5'd28, 32'h0},         '{5'd29, 32'h0},         '{5'd30, 32'h0}, '{5'd31, 32'h0}
        };
        // Inverse of 2I + N: 0.5, -0.25, 0.125, -0.0625, 0.03125 along each superdiagonal.
        inv_tab = '{
            32'h0000_8000, 32'hFFFF_C000, 32'h0000_2000, 32'hFFFF_F000, 32'h0000_0800,
            32'h0,         32'h0000_8000, 32'hFFFF_C000, 32'h0000_2000, 32'hFFFF_F000,
            32'h0,         32'h0,         32'h0000_8000, 32'hFFFF_C000, 32'h0000_2000,
            32'h0,         32'h0,         32'h0,         32'h0000_8000, 32'hFFFF_C000,
            32'h0,         32'h0,         32'h0,         32'h0,         32'h0000_8000
        };

        reset   = 1'b0;
        address = 5'd31;
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();
        check("reset_data_out", data_out, 32'h0);
        check_all_zero("reset", 1'b1);

        for (int i = 0; i < 25; i++) begin
            address = rom_tab[i].addr;
            step();
            check($sformatf("sweep_data_out_%0d", i), data_out, rom_tab[i].exp_data);
        end
        address = 5'd31;
        check_a_rom("sweep");
        wait_ad_valid("sweep1");
        check_ad_inv("sweep1");

        for (int i = 25; i < 32; i++) begin
            address = rom_tab[i].addr;
            step();
            check($sformatf("oor_data_out_%0d", i), data_out, rom_tab[i].exp_data);
        end
        check_a_rom("oor");

        address = 5'd31;
        repeat (50) step();
        check_ad_inv("hold");

        sweep(0, 24);
        address = 5'd31;
        repeat (100) step();
        #2 reset = 1'b0;
        #1;
        check("midreset_data_out", data_out, 32'h0);
        check_all_zero("midreset", 1'b1);
        step();
        reset = 1'b1;
        repeat (2) step();
        check_all_zero("post_reset", 1'b0);
        sweep(0, 24);
        address = 5'd31;
        wait_ad_valid("resweep");
        check_ad_inv("resweep");

        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        sweep(0, 23);
        address = 5'd25;
        repeat (1000) step();
        check_all_zero("partial", 1'b0);
        address = 5'd24;
        step();
        address = 5'd31;
        wait_ad_valid("complete");
        check_ad_inv("complete");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inverse_5x5.md
# inverse_5x5

Fixed-point 5×5 matrix inverter with an on-chip coefficient ROM. An external sequencer sweeps `address` across the ROM. Each addressed word is presented on `data_out` and written into the matrix register A. Once all 25 elements have been written, a Gauss-Jordan engine computes A⁻¹ into the Ad register bank. It serves as the linear-algebra core of the FPGA solver datapath, and all 50 matrix elements are exposed as flat ports for downstream logic and debug.

## Interface
- No parameters. Number format is fixed: signed two's-complement Q16.16 in 32 bits (1.0 = 0x00010000).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `address`  in  5  ROM/matrix element select. Element index k = 5·(r−1) + (c−1) for row r, column c (1..5).
- `data_out`  out  32  registered ROM word at `address`.
- `A11`..`A55`  out  32 each (25 ports)  matrix register A; Arc = row r, column c.
- `A11d`..`A55d`  out  32 each (25 ports)  computed inverse; Arcd = row r, column c of A⁻¹.

## Operation
- **ROM, 32 words:**
  - For k = 0..24 with r = k/5, c = k%5 (0-based): 0x00020000 when c = r (2.0); 0x00010000 when c = r+1 (1.0); 0 otherwise.
  - Words 25..31 read 0.
- **Every rising edge:**
  - `data_out` ← ROM[`address`].
  - If `address` < 25: A element k ← ROM[`address`], and load-mask bit k is set.
  - `address` ≥ 25 writes nothing into A and sets no mask bit.
- **Start condition:** when all 25 mask bits are set and the engine is IDLE:
  - A is copied into an internal 5×10 working array [A | I].
  - The mask is cleared and the engine goes to NORM.
- **Engine states:**
  - IDLE: waits for the start condition.
  - NORM(p): computes recip = 2³²/pivot with a sequential signed divider, then multiplies row p by recip.
  - ELIM(p): for each row i ≠ p, row i ← row i − a[i][p]·row p.
  - NEXT: p ← p+1; goes to NORM, or to DONE after p = 4.
  - DONE: copies the right half of the working array to Ad, then returns to IDLE.
- **Arithmetic rules:**
  - Product = (64-bit signed a·b) >>> 16, arithmetic shift, truncating toward −∞.
  - Sum/difference wraps modulo 2³²; there is no saturation.
  - Divide truncates toward zero.
  - No row pivoting is performed.
- **Zero pivot:** if a pivot is exactly 0, the engine aborts, writes all 25 Ad outputs to 0, and goes to IDLE.
- **A updates during compute:** A and the mask keep updating from `address` while the engine runs; the working copy is unaffected. A second full sweep completed during compute starts a new computation as soon as the engine returns to IDLE.
- **Ad stability:** Ad changes only in the DONE cycle or on a zero-pivot abort. Otherwise it holds its last result indefinitely.
- **Reset (`reset` = 0, asynchronous):**
  - `data_out`, all A, all Ad, the mask and the working array go to 0; the engine goes to IDLE.
  - Reset asserted mid-computation discards the computation.
  - After release, the mask is empty and a full 25-element sweep is required again.

## Timing
- `data_out` and the A write: 1-cycle latency from `address` being sampled.
- The start condition is evaluated on the edge after the 25th distinct element is written; the working copy is taken on that edge.
- Divider: 33 cycles per pivot. Normalize and eliminate: at most one multiply per cycle.
- Start-to-Ad-valid latency: at most 600 cycles. The exact count is implementation-defined but must be deterministic for a given input.
- `address` may change every cycle. Elements may be written in any order and repeatedly; only the last written value before the start edge is used.

## Test plan
- Reset low then released; `address` held at 31 → `data_out`, A11..A55 and A11d..A55d all read 0.
- Sweep `address` 0..24, one per cycle → after each edge `data_out` equals the ROM word (e.g. addr 0 → 0x00020000, addr 1 → 0x00010000, addr 2 → 0); A11 = 0x00020000, A12 = 0x00010000, A21 = 0.
- After the sweep plus at most 600 cycles:
  - A11d = 0x00008000, A12d = 0xFFFFC000, A13d = 0x00002000.
  - A14d = 0xFFFFF000, A15d = 0x00000800.
  - A22d = 0x00008000, A55d = 0x00008000.
  - Every element below the diagonal (A21d, A54d, …) = 0.
- Partial sweep 0..23, then `address` held at 25 for 1000 cycles → Ad remains 0.
- Reset pulsed low mid-computation → all outputs 0 immediately (asynchronous); a fresh full sweep reproduces the Ad values of the full-sweep test.
- Addresses 25..31 → `data_out` = 0, and A is unchanged.
